// File: rtl/tl_rx_demux.sv
// Receive demux: routes link words by destination field into four class FIFOs, with threshold pause and per-class counters.
// Latency: push visible in flags next cycle; pop data registered one cycle after pop_k; counter read one cycle after req.
// Backpressure: pause asserts while any class occupancy >= Umbral_alto; full-class words are dropped with drop_err. Optional: TL_RX_DROP_CNT_EN.

module fifo_sync #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_vld);
        rd_ptr_d = rd_ptr_q + AW'(rd_rdy);
        count_d  = count_q + CW'(wr_vld) - CW'(rd_rdy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign rd_dat    = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;
endmodule

module tl_rx_demux #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [2:0]        Umbral_alto,
    input  logic [2:0]        Umbral_bajo,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              pause,
    input  logic              pop_0,
    input  logic              pop_1,
    input  logic              pop_2,
    input  logic              pop_3,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              valid_0,
    output logic              valid_1,
    output logic              valid_2,
    output logic              valid_3,
    output logic [3:0]        fifo_empty,
    output logic [3:0]        fifo_full,
    output logic [3:0]        almost_empty,
    output logic              drop_err,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic [CNT_W-1:0]  contador,
    output logic              contador_valid,
    output logic              idle
);
    localparam int NCLS = 4;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

    state_t            state_q;
    logic              idle_q;

    logic [1:0]        dest;
    logic [NCLS-1:0]   pop_req, pop_eff, push, empty_now, full_now, hi_occ;
    logic              push_window;
    logic [CW-1:0]     occ [NCLS];
    logic [CW-1:0]     occ_nxt [NCLS];
    logic [DATA_W-1:0] head [NCLS];

    logic [2:0]        alto_q, alto_d, bajo_q, bajo_d;
    logic [NCLS-1:0]   empty_q, empty_d, full_q, full_d, ae_q, ae_d;
    logic              pause_q, pause_d, drop_q, drop_d;
    logic [DATA_W-1:0] dout_q [NCLS];
    logic [DATA_W-1:0] dout_d [NCLS];
    logic [NCLS-1:0]   vld_q, vld_d;
    logic [CNT_W-1:0]  del_cnt_q [NCLS];
    logic [CNT_W-1:0]  del_cnt_d [NCLS];
    logic [CNT_W-1:0]  cnt_q, cnt_d, drop_val;
    logic              cnt_vld_q, cnt_vld_d;

    assign dest        = data_in[DATA_W-1 -: 2];
    assign pop_req     = {pop_3, pop_2, pop_1, pop_0};
    assign push_window = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

    for (genvar k = 0; k < NCLS; k++) begin : g_cls
        fifo_sync #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (reset),
            .wr_vld    (push[k]),
            .wr_dat    (data_in),
            .rd_rdy    (pop_eff[k]),
            .rd_dat    (head[k]),
            .count     (occ[k]),
            .count_nxt (occ_nxt[k])
        );
    end

`ifdef TL_RX_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt_d = drop_cnt_q + CNT_W'(drop_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_val = drop_cnt_q;
`else
    assign drop_val = '0;
`endif

    always_comb begin
        push    = '0;
        drop_d  = 1'b0;
        pop_eff = '0;
        for (int k = 0; k < NCLS; k++) begin
            empty_now[k] = (occ[k] == '0);
            full_now[k]  = (occ[k] == CW'(FIFO_DEPTH));
            pop_eff[k]   = pop_req[k] && !empty_now[k];
        end
        // A pop on a full class frees the slot in the same cycle, so no drop.
        if (valid_in && push_window) begin
            if (full_now[dest] && !pop_eff[dest]) drop_d = 1'b1;
            else                                  push[dest] = 1'b1;
        end
    end

    always_comb begin
        alto_d = alto_q;
        bajo_d = bajo_q;
        if (state_q == ST_INIT && init) begin
            alto_d = Umbral_alto;
            bajo_d = Umbral_bajo;
        end
        empty_d = '0;
        full_d  = '0;
        ae_d    = '0;
        hi_occ  = '0;
        for (int k = 0; k < NCLS; k++) begin
            empty_d[k]   = (occ_nxt[k] == '0);
            full_d[k]    = (occ_nxt[k] == CW'(FIFO_DEPTH));
            ae_d[k]      = (32'(occ_nxt[k]) <= 32'(bajo_d));
            hi_occ[k]    = (32'(occ_nxt[k]) >= 32'(alto_d));
            dout_d[k]    = pop_eff[k] ? head[k] : dout_q[k];
            del_cnt_d[k] = del_cnt_q[k] + CNT_W'(pop_eff[k]);
        end
        pause_d = |hi_occ;
        vld_d   = pop_eff;
    end

    always_comb begin
        cnt_vld_d = req;
        cnt_d     = cnt_q;
        if (req) begin
            case (idx)
                3'd0, 3'd1, 3'd2, 3'd3: cnt_d = del_cnt_q[idx[1:0]];
                3'd4:                   cnt_d = drop_val;
                default:                cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            idle_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: state_q <= ST_INIT;
                ST_INIT: begin
                    if (!init) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        state_q <= ST_INIT;
                        idle_q  <= 1'b0;
                    end else if (|push) begin
                        state_q <= ST_ACTIVE;
                        idle_q  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (init) begin
                        state_q <= ST_INIT;
                    end else if ((&empty_now) && !valid_in) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RESET;
                    idle_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alto_q    <= '0;
            bajo_q    <= '0;
            empty_q   <= '1;
            full_q    <= '0;
            ae_q      <= '1;
            pause_q   <= 1'b0;
            drop_q    <= 1'b0;
            vld_q     <= '0;
            cnt_q     <= '0;
            cnt_vld_q <= 1'b0;
            for (int k = 0; k < NCLS; k++) begin
                dout_q[k]    <= '0;
                del_cnt_q[k] <= '0;
            end
        end else begin
            alto_q    <= alto_d;
            bajo_q    <= bajo_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ae_q      <= ae_d;
            pause_q   <= pause_d;
            drop_q    <= drop_d;
            vld_q     <= vld_d;
            cnt_q     <= cnt_d;
            cnt_vld_q <= cnt_vld_d;
            for (int k = 0; k < NCLS; k++) begin
                dout_q[k]    <= dout_d[k];
                del_cnt_q[k] <= del_cnt_d[k];
            end
        end
    end

    assign data_out0      = dout_q[0];
    assign data_out1      = dout_q[1];
    assign data_out2      = dout_q[2];
    assign data_out3      = dout_q[3];
    assign valid_0        = vld_q[0];
    assign valid_1        = vld_q[1];
    assign valid_2        = vld_q[2];
    assign valid_3        = vld_q[3];
    assign fifo_empty     = empty_q;
    assign fifo_full      = full_q;
    assign almost_empty   = ae_q;
    assign pause          = pause_q;
    assign drop_err       = drop_q;
    assign contador       = cnt_q;
    assign contador_valid = cnt_vld_q;
    assign idle           = idle_q;
endmodule

// File: tb/tb_tl_rx_demux.sv
// Bench for tl_rx_demux: directed stimulus pushes expected words/counter values into queues; a negedge monitor pops and compares.
module tb_tl_rx_demux;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic [2:0]  ua = 3'd0, ub = 3'd0;
    logic [11:0] data_in = 12'h0;
    logic        valid_in = 1'b0;
    logic        pause;
    logic [3:0]  pop_v = 4'h0;
    logic [11:0] data_out0, data_out1, data_out2, data_out3;
    logic        valid_0, valid_1, valid_2, valid_3;
    logic [3:0]  fifo_empty, fifo_full, almost_empty;
    logic        drop_err;
    logic        req = 1'b0;
    logic [2:0]  idx = 3'd0;
    logic [4:0]  contador;
    logic        contador_valid;
    logic        idle;

`ifdef TL_RX_DROP_CNT_EN
    localparam logic [4:0] EXP_DROP = 5'd1;
`else
    localparam logic [4:0] EXP_DROP = 5'd0;
`endif

    tl_rx_demux dut (
        .clk(clk), .reset(reset), .init(init),
        .Umbral_alto(ua), .Umbral_bajo(ub),
        .data_in(data_in), .valid_in(valid_in), .pause(pause),
        .pop_0(pop_v[0]), .pop_1(pop_v[1]), .pop_2(pop_v[2]), .pop_3(pop_v[3]),
        .data_out0(data_out0), .data_out1(data_out1),
        .data_out2(data_out2), .data_out3(data_out3),
        .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_empty(almost_empty),
        .drop_err(drop_err), .req(req), .idx(idx),
        .contador(contador), .contador_valid(contador_valid), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q [4][$];
    logic [4:0]  exp_cnt_q [$];
    logic [11:0] dout [4];
    logic [3:0]  vld;
    logic [11:0] mon_e;
    logic [4:0]  mon_c;

    assign dout[0] = data_out0;
    assign dout[1] = data_out1;
    assign dout[2] = data_out2;
    assign dout[3] = data_out3;
    assign vld     = {valid_3, valid_2, valid_1, valid_0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid_%0d: got data %0h, required no output", k, dout[k]);
                    end else begin
                        mon_e = exp_q[k].pop_front();
                        chk($sformatf("data_out%0d", k), 32'(dout[k]), 32'(mon_e));
                    end
                end
            end
            if (contador_valid) begin
                if (exp_cnt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_contador_valid: got %0h, required no output", contador);
                end else begin
                    mon_c = exp_cnt_q.pop_front();
                    chk("contador", 32'(contador), 32'(mon_c));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [11:0] w, input bit keep);
        logic [1:0] c;
        c = w[11:10];
        data_in  = w;
        valid_in = 1'b1;
        if (keep) exp_q[c].push_back(w);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic do_init();
        init = 1'b1;
        ua   = 3'd3;
        ub   = 3'd1;
        tick();
        tick();
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic read_cnt(input logic [2:0] sel, input logic [4:0] exp);
        req = 1'b1;
        idx = sel;
        exp_cnt_q.push_back(exp);
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pause"}, 32'(pause), 32'h0);
        chk({tag, "_drop_err"}, 32'(drop_err), 32'h0);
        chk({tag, "_idle"}, 32'(idle), 32'h0);
        chk({tag, "_fifo_empty"}, 32'(fifo_empty), 32'hF);
        chk({tag, "_fifo_full"}, 32'(fifo_full), 32'h0);
        chk({tag, "_almost_empty"}, 32'(almost_empty), 32'hF);
        chk({tag, "_contador"}, 32'(contador), 32'h0);
        chk({tag, "_contador_valid"}, 32'(contador_valid), 32'h0);
        chk({tag, "_valids"}, 32'(vld), 32'h0);
        chk({tag, "_data_out0"}, 32'(data_out0), 32'h0);
        chk({tag, "_data_out1"}, 32'(data_out1), 32'h0);
        chk({tag, "_data_out3"}, 32'(data_out3), 32'h0);
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 check_reset_vals("rst");
        tick();
        tick();
        reset = 1'b1;
        do_init();
        chk("init_idle", 32'(idle), 32'h1);
        chk("init_empty", 32'(fifo_empty), 32'hF);
        chk("init_pause", 32'(pause), 32'h0);

        // One word per class 0/1/3, popped together.
        push_word(12'h0A5, 1'b1);
        chk("active_idle", 32'(idle), 32'h0);
        push_word(12'h5A1, 1'b1);
        push_word(12'hFFF, 1'b1);
        pop_v = 4'b1011;
        tick();
        pop_v = 4'b0000;
        tick();
        tick();
        chk("back_idle", 32'(idle), 32'h1);
        chk("drained_empty", 32'(fifo_empty), 32'hF);
        pop_v = 4'b1000;
        tick();
        pop_v = 4'b0000;
        chk("empty_pop_hold", 32'(data_out3), 32'hFFF);
        chk("empty_pop_valid", 32'(valid_3), 32'h0);

        // Class 2 thresholds, full and drop.
        push_word(12'h801, 1'b1);
        chk("ae_occ1", 32'(almost_empty), 32'hF);
        chk("pause_occ1", 32'(pause), 32'h0);
        push_word(12'h802, 1'b1);
        chk("ae_occ2", 32'(almost_empty), 32'hB);
        chk("pause_occ2", 32'(pause), 32'h0);
        push_word(12'h803, 1'b1);
        chk("pause_occ3", 32'(pause), 32'h1);
        pop_v = 4'b0100;
        tick();
        pop_v = 4'b0000;
        chk("pause_after_pop", 32'(pause), 32'h0);
        push_word(12'h804, 1'b1);
        push_word(12'h805, 1'b1);
        chk("full_2", 32'(fifo_full), 32'h4);
        chk("no_drop_yet", 32'(drop_err), 32'h0);
        push_word(12'h806, 1'b0);
        chk("drop_err", 32'(drop_err), 32'h1);
        tick();
        chk("drop_err_pulse", 32'(drop_err), 32'h0);

        // Push and pop on a full class in the same cycle.
        data_in  = 12'h807;
        valid_in = 1'b1;
        pop_v    = 4'b0100;
        exp_q[2].push_back(12'h807);
        tick();
        valid_in = 1'b0;
        pop_v    = 4'b0000;
        chk("pushpop_no_drop", 32'(drop_err), 32'h0);
        chk("pushpop_full", 32'(fifo_full), 32'h4);
        pop_v = 4'b0100;
        repeat (4) tick();
        pop_v = 4'b0000;
        chk("class2_drained", 32'(fifo_empty), 32'hF);

        // 32 more class-0 deliveries: total 33 wraps to 1.
        for (int i = 0; i < 32; i++) begin
            push_word(12'(i), 1'b1);
            pop_v = 4'b0001;
            tick();
            pop_v = 4'b0000;
        end
        read_cnt(3'd0, 5'd1);
        read_cnt(3'd4, EXP_DROP);
        read_cnt(3'd2, 5'd6);
        read_cnt(3'd6, 5'd0);
        read_cnt(3'd3, 5'd1);
        req = 1'b0;
        tick();
        chk("cnt_valid_low", 32'(contador_valid), 32'h0);
        chk("cnt_hold", 32'(contador), 32'h1);

        // Asynchronous reset with words still queued in class 1.
        push_word(12'h401, 1'b1);
        push_word(12'h402, 1'b1);
        reset = 1'b0;
        exp_q[1].delete();
        #1 check_reset_vals("midrst");
        tick();
        reset = 1'b1;
        do_init();
        chk("reinit_empty", 32'(fifo_empty), 32'hF);
        read_cnt(3'd1, 5'd0);
        read_cnt(3'd2, 5'd0);
        req = 1'b0;
        tick();
        tick();

        chk("scoreboard_drained",
            32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() + exp_cnt_q.size()),
            32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tl_rx_demux.md
Name: tl_rx_demux

Overview:
- Receive-side counterpart of the PCIe transaction-layer transmit path.
- Accepts a single 12-bit word stream from the link side and routes each word by destination field into one of four per-class output FIFOs.
- Drives pause backpressure to the sender from programmable thresholds (Umbral_alto / Umbral_bajo).
- Keeps per-class delivered-word counters readable via req/idx.

Parameters:
DATA_W, 12, word width; destination field is data_in[DATA_W-1:DATA_W-2]
FIFO_DEPTH, 4, entries per class FIFO (power of two)
CNT_W, 5, width of delivered/drop counters

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
init  input  1  threshold-load request
Umbral_alto  input  3  almost-full threshold, occupancy
Umbral_bajo  input  3  almost-empty threshold, occupancy
data_in  input  DATA_W  incoming word
valid_in  input  1  data_in qualifier
pause  output  1  backpressure to sender
pop_0..pop_3  input  1 each  class-k read request
data_out0..data_out3  output  DATA_W each  class-k read data
valid_0..valid_3  output  1 each  class-k read data valid
fifo_empty  output  4  per-class empty
fifo_full  output  4  per-class full
almost_empty  output  4  per-class occupancy <= Umbral_bajo
drop_err  output  1  word discarded this cycle
req  input  1  counter read request
idx  input  3  counter select
contador  output  CNT_W  counter read data
contador_valid  output  1  contador qualifier
idle  output  1  block idle

Behaviour:
- Reset (reset=0, async): state=RESET; FIFOs emptied; all counters 0; thresholds 0.
- Reset values: data_out*=0, valid_*=0, contador=0, contador_valid=0, pause=0, drop_err=0, idle=0, fifo_empty=4'hF, fifo_full=0, almost_empty=4'hF.
- FSM states: RESET, INIT, IDLE, ACTIVE.
  - RESET -> INIT on first clock with reset=1.
  - INIT: Umbral_alto/Umbral_bajo registered every cycle while init=1; on init=0 -> IDLE.
  - IDLE: idle=1. Accepted word -> ACTIVE.
  - ACTIVE: when all FIFOs empty and valid_in=0 -> IDLE.
  - init=1 in IDLE or ACTIVE -> INIT. FIFO contents and counters are preserved across INIT.
- Push:
  - Only in IDLE/ACTIVE. Words with valid_in=1 in RESET/INIT are discarded without drop_err.
  - Destination k = data_in[11:10]. If FIFO k is not full, the word is written there.
  - If FIFO k is full, the word is dropped, drop_err=1 for one cycle, and the drop counter increments.
- Pop:
  - pop_k=1 with FIFO k non-empty: data_out_k = head word on the next clock edge, valid_k=1 for that cycle, delivered counter k increments.
  - pop_k on an empty FIFO: valid_k=0 and data_out_k holds its last value.
- Simultaneous push and pop on the same FIFO: both take effect and occupancy is unchanged. When the FIFO is full, the push is accepted (pop frees the slot in the same cycle, no drop). Pops on different FIFOs are independent.
- Flags (registered, reflect post-update occupancy):
  - fifo_full = occupancy==FIFO_DEPTH; fifo_empty = occupancy==0.
  - almost_empty[k] = occupancy_k <= Umbral_bajo.
  - pause = OR over k of (occupancy_k >= Umbral_alto). A threshold of 0 forces pause=1.
- Pointers wrap modulo FIFO_DEPTH. Counters wrap 31->0, with no saturation.
- Counter read:
  - req=1 samples idx; next cycle contador_valid=1 for one cycle.
  - idx 0..3: contador = delivered count of that class. idx 4: drop count (see feature). idx 5..7: contador=0.
  - req=0: contador_valid=0 and contador holds.
- Reset asserted mid-operation clears everything immediately (async); in-flight words are lost.

Optional Feature:
- Macro: TL_RX_DROP_CNT_EN.
- Defined: drop counter implemented; idx=4 returns its value.
- Undefined: no drop counter; idx=4 returns 0. drop_err behaves the same in both cases.

Test Plan:
- Reset release, init=1 with Umbral_alto=3, Umbral_bajo=1, then init=0 -> state IDLE, idle=1, fifo_empty=4'hF, pause=0.
- Push 12'h0A5 (class 0), 12'h5A1 (class 1), 12'hFFF (class 3); pop_0, pop_1, pop_3 -> next cycles data_out0=0A5, data_out1=5A1, data_out3=FFF, each valid one cycle; idle returns to 1.
- Push 3 words to class 2 -> pause=1 after the third push. Pop one -> pause=0. Push 2 more -> fifo_full[2]=1. Push a fifth -> drop_err=1, word lost.
- Class 2 full, push and pop_2 in the same cycle -> no drop_err, fifo_full[2] stays 1, popped word is the oldest.
- 33 pops from class 0 then req with idx=0 -> contador=1 (wrap), contador_valid=1 one cycle. With TL_RX_DROP_CNT_EN and 1 prior drop, idx=4 -> 1; without it -> 0.
- Assert reset mid-stream with 2 words in class 1 -> all outputs at reset values immediately, fifo_empty=4'hF, counters 0.
